// File: rtl/mem_master.sv
// mem_master: request-to-memory bridge FSM; define MEM_MASTER_BURST_EN for req_len+1 beat bursts
module mem_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] mem_w,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_out
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic [2:0]        cnt;
  logic [2:0]        len_in;
`ifdef MEM_MASTER_BURST_EN
  assign len_in = req_len;
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign len_in = '0;
`endif
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign mem_w     = DATA_W'(state == WRITE);
  assign mem_a     = (state == WRITE || state == READ) ? addr : '0;
  assign mem_d     = state == WRITE ? wdata : '0;
  // sequencing of accept, memory beats and response handshakes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      wr        <= 1'b0;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            addr  <= req_addr;
            wdata <= req_wdata;
            wr    <= req_write;
            cnt   <= len_in;
            state <= req_write ? WRITE : READ;
          end
        WRITE:
          if (cnt == '0) begin
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
          end
        READ: begin
          rsp_rdata <= mem_out;
          state     <= RESP;
        end
        default:
          if (rsp_ready) begin
            if (!wr && cnt != '0) begin
              addr  <= addr + 1'b1;
              cnt   <= cnt - 1'b1;
              state <= READ;
            end else
              state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed self-checking bench for mem_master with a combinational memory model
module tb_mem_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [2:0]  req_len;
  logic        rsp_valid, rsp_ready, busy;
  logic [15:0] rsp_rdata, mem_w, mem_a, mem_d, mem_out;
  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_w(mem_w), .mem_a(mem_a), .mem_d(mem_d), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  assign mem_out = mem[mem_a];

  always @(posedge clk)
    if (mem_w[0]) mem[mem_a] <= mem_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [2:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_len   = l;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'hDEAD;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_w", mem_w, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_d", mem_d, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);

    // store addr 4 data 6
    issue(1'b1, 16'd4, 16'd6, 3'd0);
    step();
    chk("st_mem_w", mem_w, 1);
    chk("st_mem_a", mem_a, 4);
    chk("st_mem_d", mem_d, 6);
    chk("st_busy", busy, 1);
    chk("st_req_ready", req_ready, 0);
    chk("st_rsp_early", rsp_valid, 0);
    req_valid = 1'b0;
    step();
    chk("st_ack_valid", rsp_valid, 1);
    chk("st_ack_rdata", rsp_rdata, 0);
    chk("st_one_write", mem_w, 0);
    chk("st_mem4", mem[4], 16'd6);
    rsp_ready = 1'b1;
    step();
    chk("st_done_valid", rsp_valid, 0);
    chk("st_done_ready", req_ready, 1);
    rsp_ready = 1'b0;

    // load addr 4 with three-cycle response stall; req_valid left high is ignored
    issue(1'b0, 16'd4, 16'd0, 3'd0);
    step();
    chk("ld_mem_w", mem_w, 0);
    chk("ld_mem_a", mem_a, 4);
    chk("ld_rsp_early", rsp_valid, 0);
    step();
    chk("ld_valid", rsp_valid, 1);
    chk("ld_rdata", rsp_rdata, 6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 6);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_mem_w", mem_w, 0);
      chk("stall_mem_a", mem_a, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("ld_done_valid", rsp_valid, 0);
    chk("ld_done_busy", busy, 0);

    // load unwritten addr 9 with rsp_ready already high
    issue(1'b0, 16'd9, 16'd0, 3'd0);
    step();
    chk("ld9_mem_a", mem_a, 9);
    req_valid = 1'b0;
    step();
    chk("ld9_valid", rsp_valid, 1);
    chk("ld9_rdata", rsp_rdata, 16'hDEAD);
    step();
    chk("ld9_done", busy, 0);

`ifndef MEM_MASTER_BURST_EN
    // req_len ignored: single write only
    issue(1'b1, 16'd20, 16'd7, 3'd3);
    step();
    chk("nb_mem_a", mem_a, 20);
    req_valid = 1'b0;
    step();
    chk("nb_ack", rsp_valid, 1);
    chk("nb_mem_w", mem_w, 0);
    step();
    chk("nb_idle", busy, 0);
    chk("nb_mem20", mem[20], 16'd7);
    chk("nb_mem21", mem[21], 16'hDEAD);
`else
    // burst store fill addr 4..5
    issue(1'b1, 16'd4, 16'd9, 3'd1);
    step();
    chk("bs_a0", mem_a, 4);
    req_valid = 1'b0;
    step();
    chk("bs_a1", mem_a, 5);
    chk("bs_w1", mem_w, 1);
    chk("bs_ack0", rsp_valid, 0);
    step();
    chk("bs_ack", rsp_valid, 1);
    chk("bs_ack_rdata", rsp_rdata, 0);
    step();
    chk("bs_idle", busy, 0);
    chk("bs_mem4", mem[4], 16'd9);
    chk("bs_mem5", mem[5], 16'd9);
    // burst load addr 4..5
    issue(1'b0, 16'd4, 16'd0, 3'd1);
    step();
    chk("bl_a0", mem_a, 4);
    req_valid = 1'b0;
    step();
    chk("bl_v0", rsp_valid, 1);
    chk("bl_d0", rsp_rdata, 9);
    step();
    chk("bl_a1", mem_a, 5);
    chk("bl_nv", rsp_valid, 0);
    step();
    chk("bl_v1", rsp_valid, 1);
    chk("bl_d1", rsp_rdata, 9);
    step();
    chk("bl_idle", busy, 0);
    // burst load across address wrap
    issue(1'b0, 16'hFFFF, 16'd0, 3'd1);
    step();
    chk("wr_a0", mem_a, 16'hFFFF);
    req_valid = 1'b0;
    step();
    chk("wr_v0", rsp_valid, 1);
    step();
    chk("wr_a1", mem_a, 16'h0000);
    step();
    chk("wr_v1", rsp_valid, 1);
    step();
    chk("wr_idle", busy, 0);
`endif

    // reset during WRITE of a len 3 store
    issue(1'b1, 16'd30, 16'd5, 3'd3);
    step();
    chk("rw_mem_w", mem_w, 1);
    req_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rw_mem_w_kill", mem_w, 0);
    chk("rw_busy", busy, 0);
    chk("rw_mem_a", mem_a, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw_no_rsp", rsp_valid, 0);
      chk("rw_no_write", mem_w, 0);
    end
    chk("rw_mem30", mem[30], 16'hDEAD);
    chk("rw_mem31", mem[31], 16'hDEAD);
    chk("rw_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
